// File: rtl/speck_uart_cmd_parser_if.sv
// Command handshake bundle between the UART command parser and the Speck
// command controller. The parser is the master (it offers commands), and the
// controller is the slave (it accepts them with cmd_ready).
interface speck_uart_cmd_parser_if #(
    parameter int W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [4*W-1:0]   cmd_key;
    logic [2*W-1:0]   cmd_block;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_key,
        output cmd_block,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_key,
        input  cmd_block,
        output cmd_ready
    );
endinterface

// File: rtl/speck_uart_cmd_parser.sv
// Speck UART command parser: frames the received byte stream into KEY ('K'),
// ENC ('E') and DEC ('D') commands with little-endian payloads and offers them
// on a valid/ready handshake. Flags unknown opcodes, stalled frames and bytes
// that arrive while a command is still waiting for the controller.
// Optional build macro SPECK_CMD_LOWERCASE_EN also accepts 'k', 'e' and 'd'.
module speck_uart_cmd_parser #(
    parameter int W             = 32,
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    speck_uart_cmd_parser_if.master cmd,
    output logic                    busy,
    output logic                    err_unknown,
    output logic                    err_timeout,
    output logic                    err_overrun
);
    localparam int KEY_BYTES = W / 2;
    localparam int BLK_BYTES = W / 4;
    localparam int CNT_W     = $clog2(KEY_BYTES);

    // 64-bit arithmetic: TIMEOUT_BYTES*10*CLK_FREQ overflows 32 bits at defaults.
    localparam longint TO_CYC = (longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLK_FREQ))
                                / longint'(BAUD_RATE);
    localparam int TO_W = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    localparam logic [1:0] OP_KEY = 2'd0;
    localparam logic [1:0] OP_ENC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic [1:0]        op_dec;
    logic              op_hit;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   to_q;
    logic [4*W-1:0]    key_q;
    logic [2*W-1:0]    block_q;

    logic handshake;
    logic opcode_slot;
    logic take_op;
    logic unknown_hit;
    logic store_byte;
    logic last_byte;
    logic timeout_hit;
    logic overrun_hit;

    // Classify the incoming byte as one of the recognised opcodes.
    always_comb begin
        op_hit = 1'b1;
        op_dec = OP_KEY;
        case (rx_data)
            8'h4B:   op_dec = OP_KEY;
            8'h45:   op_dec = OP_ENC;
            8'h44:   op_dec = OP_DEC;
`ifdef SPECK_CMD_LOWERCASE_EN
            8'h6B:   op_dec = OP_KEY;
            8'h65:   op_dec = OP_ENC;
            8'h64:   op_dec = OP_DEC;
`else
`endif
            default: op_hit = 1'b0;
        endcase
    end

    // Byte-level events; a byte landing on the handshake cycle is read as a fresh opcode.
    always_comb begin
        handshake   = (state == HOLD) && cmd.cmd_ready;
        opcode_slot = rx_valid && ((state == IDLE) || handshake);
        take_op     = opcode_slot && op_hit;
        unknown_hit = opcode_slot && !op_hit;
        store_byte  = (state == COLLECT) && rx_valid;
        last_byte   = (op_q == OP_KEY) ? (cnt_q == CNT_W'(KEY_BYTES - 1))
                                       : (cnt_q == CNT_W'(BLK_BYTES - 1));
        timeout_hit = (state == COLLECT) && !rx_valid && (to_q == TO_LAST);
        overrun_hit = (state == HOLD) && !cmd.cmd_ready && rx_valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_op) state_nxt = COLLECT;
            COLLECT: begin
                if (store_byte && last_byte) state_nxt = HOLD;
                else if (timeout_hit)        state_nxt = IDLE;
            end
            HOLD:    if (handshake) state_nxt = take_op ? COLLECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs follow the state and the held command registers.
    always_comb begin
        cmd.cmd_valid = (state == HOLD);
        cmd.cmd_op    = op_q;
        cmd.cmd_key   = key_q;
        cmd.cmd_block = block_q;
        busy          = (state != IDLE);
    end

    // Opcode latch, byte counter and little-endian payload assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_KEY;
            cnt_q   <= '0;
            key_q   <= '0;
            block_q <= '0;
        end else if (take_op) begin
            op_q  <= op_dec;
            cnt_q <= '0;
            if (op_dec == OP_KEY) key_q   <= '0;
            else                  block_q <= '0;
        end else if (store_byte) begin
            cnt_q <= cnt_q + 1'b1;
            for (int i = 0; i < KEY_BYTES; i++) begin
                if ((op_q == OP_KEY) && (cnt_q == CNT_W'(i))) key_q[8*i +: 8] <= rx_data;
            end
            for (int i = 0; i < BLK_BYTES; i++) begin
                if ((op_q != OP_KEY) && (cnt_q == CNT_W'(i))) block_q[8*i +: 8] <= rx_data;
            end
        end
    end

    // Inter-byte gap counter; only runs while a frame is being collected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= '0;
        end else if ((state == COLLECT) && !rx_valid && !timeout_hit) begin
            to_q <= to_q + 1'b1;
        end else begin
            to_q <= '0;
        end
    end

    // Single-cycle error pulses, registered one cycle after the offending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unknown <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_unknown <= unknown_hit;
            err_timeout <= timeout_hit;
            err_overrun <= overrun_hit;
        end
    end
endmodule

// File: tb/tb_speck_uart_cmd_parser.sv
// Testbench for speck_uart_cmd_parser: table of framed commands plus
// hand-written sequences for hold, overrun, handshake-coincident opcode,
// timeout and mid-frame reset. Expected commands go through a scoreboard.
module tb_speck_uart_cmd_parser;
    localparam int W      = 32;
    localparam int TO_CYC = 34722;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       busy;
    logic       err_unknown;
    logic       err_timeout;
    logic       err_overrun;

    speck_uart_cmd_parser_if #(.W(W)) cmd_if ();

    speck_uart_cmd_parser #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd         (cmd_if),
        .busy        (busy),
        .err_unknown (err_unknown),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [127:0] key;
        logic [63:0]  block;
    } exp_cmd_t;

    typedef struct {
        logic [7:0]   opc;
        logic [127:0] pay;
        int           n;
        bit           accept;
    } vec_t;

    exp_cmd_t     sb[$];
    exp_cmd_t     mon_e;
    vec_t         vecs[7];
    int           n_vec     = 0;
    int           n_miss    = 0;
    int           unk_cnt   = 0;
    int           to_cnt    = 0;
    int           ovr_cnt   = 0;
    int           valid_cnt = 0;
    logic [1:0]   m_op      = 2'd0;
    logic [127:0] m_key     = '0;
    logic [63:0]  m_block   = '0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Error pulse counters and scoreboard pop on every accepted command.
    always @(negedge clk) begin
        if (err_unknown) unk_cnt++;
        if (err_timeout) to_cnt++;
        if (err_overrun) ovr_cnt++;
        if (cmd_if.cmd_valid) valid_cnt++;
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL sb_unexpected: got command op %0d, expected none", cmd_if.cmd_op);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_op", 128'(cmd_if.cmd_op), 128'(mon_e.op));
                checkOutput("sb_key", cmd_if.cmd_key, mon_e.key);
                checkOutput("sb_block", 128'(cmd_if.cmd_block), 128'(mon_e.block));
            end
        end
    end

    function automatic logic [2:0] decodeOp(input logic [7:0] b);
        case (b)
            8'h4B: return 3'b100;
            8'h45: return 3'b101;
            8'h44: return 3'b110;
`ifdef SPECK_CMD_LOWERCASE_EN
            8'h6B: return 3'b100;
            8'h65: return 3'b101;
            8'h64: return 3'b110;
`else
`endif
            default: return 3'b000;
        endcase
    endfunction

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic modelOpcode(input logic [7:0] b);
        logic [2:0] d;
        d = decodeOp(b);
        if (d[2]) begin
            m_op = d[1:0];
            if (m_op == 2'd0) m_key = '0;
            else              m_block = '0;
        end
    endtask

    task automatic sendPayload(input logic [127:0] pay, input int first, input int n, input bit push_last);
        for (int i = first; i < n; i++) begin
            if (m_op == 2'd0) m_key[8*i +: 8] = pay[8*i +: 8];
            else              m_block[8*i +: 8] = pay[8*i +: 8];
            if (push_last && (i == n - 1)) sb.push_back('{m_op, m_key, m_block});
            sendByte(pay[8*i +: 8]);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] opc, input logic [127:0] pay, input int n, input bit push_last);
        sendByte(opc);
        modelOpcode(opc);
        sendPayload(pay, 0, n, push_last);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_unk;
        int base_to;
        int base_ovr;
        int base_valid;
        int n;
        bit held_ok;

        vecs[0] = '{8'h4B, 128'h1b1a1918_13121110_0b0a0908_03020100, 16, 1'b1};
        vecs[1] = '{8'h45, 128'h3b7265747475432d, 8, 1'b1};
        vecs[2] = '{8'h44, 128'h0123456789abcdef, 8, 1'b1};
        vecs[3] = '{8'h5A, 128'h0, 0, 1'b0};
        vecs[4] = '{8'h45, 128'h4b4b4b4b4b4b4b4b, 8, 1'b1};
`ifdef SPECK_CMD_LOWERCASE_EN
        vecs[5] = '{8'h6B, 128'hdeadbeef_4b454400_cafef00d_12345678, 16, 1'b1};
`else
        vecs[5] = '{8'h6B, 128'h0, 0, 1'b0};
`endif
        vecs[6] = '{8'h4B, 128'h44454b4b_00ff4b44_a5a55a5a_45444b6b, 16, 1'b1};

        cmd_if.cmd_ready = 1'b1;
        #1 rst_n = 1'b0;
        waitCycles(3);
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_valid", 128'(cmd_if.cmd_valid), 128'(0));
        checkOutput("rst_op", 128'(cmd_if.cmd_op), 128'(0));
        checkOutput("rst_key", cmd_if.cmd_key, 128'(0));
        checkOutput("rst_block", 128'(cmd_if.cmd_block), 128'(0));
        checkOutput("rst_errs", 128'({err_unknown, err_timeout, err_overrun}), 128'(0));
        rst_n = 1'b1;
        waitCycles(2);

        // Table of framed commands with cmd_ready held high.
        for (int v = 0; v < 7; v++) begin
            base_unk   = unk_cnt;
            base_valid = valid_cnt;
            applyStimulus(vecs[v].opc, vecs[v].pay, vecs[v].n, vecs[v].accept);
            waitCycles(3);
            checkOutput($sformatf("vec%0d_sb_empty", v), 128'(sb.size()), 128'(0));
            checkOutput($sformatf("vec%0d_valid_pulses", v), 128'(valid_cnt - base_valid), 128'(vecs[v].accept ? 1 : 0));
            checkOutput($sformatf("vec%0d_unknown", v), 128'(unk_cnt - base_unk), 128'(vecs[v].accept ? 0 : 1));
            checkOutput($sformatf("vec%0d_busy", v), 128'(busy), 128'(0));
        end

        // Command held for 100 cycles with cmd_ready low, then released.
        cmd_if.cmd_ready = 1'b0;
        applyStimulus(8'h45, 128'h3b7265747475432d, 8, 1'b1);
        held_ok = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (!cmd_if.cmd_valid || (cmd_if.cmd_block !== 64'h3b7265747475432d) || (cmd_if.cmd_op !== 2'd1))
                held_ok = 1'b0;
        end
        checkOutput("hold_stable", 128'(held_ok), 128'(1));
        cmd_if.cmd_ready = 1'b1;
        waitCycles(1);
        checkOutput("hold_valid_drop", 128'(cmd_if.cmd_valid), 128'(0));
        checkOutput("hold_busy", 128'(busy), 128'(0));
        checkOutput("hold_sb_empty", 128'(sb.size()), 128'(0));

        // Byte arriving during HOLD is dropped and flagged.
        cmd_if.cmd_ready = 1'b0;
        applyStimulus(8'h44, 128'h1122334455667788, 8, 1'b1);
        base_ovr = ovr_cnt;
        base_unk = unk_cnt;
        sendByte(8'h45);
        waitCycles(2);
        checkOutput("ovr_pulse", 128'(ovr_cnt - base_ovr), 128'(1));
        checkOutput("ovr_no_unknown", 128'(unk_cnt - base_unk), 128'(0));
        checkOutput("ovr_block", 128'(cmd_if.cmd_block), 128'(64'h1122334455667788));
        checkOutput("ovr_op", 128'(cmd_if.cmd_op), 128'(2));
        checkOutput("ovr_valid", 128'(cmd_if.cmd_valid), 128'(1));
        cmd_if.cmd_ready = 1'b1;
        waitCycles(1);
        checkOutput("ovr_idle", 128'(busy), 128'(0));
        applyStimulus(8'h45, 128'h8877665544332211, 8, 1'b1);
        waitCycles(3);
        checkOutput("ovr_next_sb_empty", 128'(sb.size()), 128'(0));

        // Opcode on the handshake cycle starts the next frame without overrun.
        cmd_if.cmd_ready = 1'b0;
        applyStimulus(8'h45, 128'h0f0e0d0c0b0a0908, 8, 1'b1);
        base_ovr = ovr_cnt;
        base_unk = unk_cnt;
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        waitCycles(1);
        rx_valid = 1'b0;
        modelOpcode(8'h44);
        checkOutput("hs_busy", 128'(busy), 128'(1));
        checkOutput("hs_valid", 128'(cmd_if.cmd_valid), 128'(0));
        sendPayload(128'h7766554433221100, 0, 8, 1'b1);
        waitCycles(3);
        checkOutput("hs_no_overrun", 128'(ovr_cnt - base_ovr), 128'(0));
        checkOutput("hs_no_unknown", 128'(unk_cnt - base_unk), 128'(0));
        checkOutput("hs_sb_empty", 128'(sb.size()), 128'(0));

        // Stalled frame times out exactly TO_CYC cycles after the last byte.
        base_to    = to_cnt;
        base_valid = valid_cnt;
        applyStimulus(8'h44, 128'h2211, 2, 1'b0);
        n = 0;
        while (!err_timeout && (n < 40000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("to_cycles", 128'(n), 128'(TO_CYC));
        waitCycles(2);
        checkOutput("to_pulse", 128'(to_cnt - base_to), 128'(1));
        checkOutput("to_no_valid", 128'(valid_cnt - base_valid), 128'(0));
        checkOutput("to_busy", 128'(busy), 128'(0));

        // A gap one cycle short of the limit still completes the frame.
        base_to = to_cnt;
        applyStimulus(8'h44, 128'h8877665544332211, 2, 1'b0);
        repeat (TO_CYC - 1) @(posedge clk);
        #1;
        sendPayload(128'h8877665544332211, 2, 8, 1'b1);
        waitCycles(3);
        checkOutput("gap_no_timeout", 128'(to_cnt - base_to), 128'(0));
        checkOutput("gap_sb_empty", 128'(sb.size()), 128'(0));

        // Reset in the middle of a key frame.
        base_unk = unk_cnt;
        base_to  = to_cnt;
        base_ovr = ovr_cnt;
        applyStimulus(8'h4B, 128'h0504030201, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 128'(busy), 128'(0));
        checkOutput("mid_rst_valid", 128'(cmd_if.cmd_valid), 128'(0));
        checkOutput("mid_rst_key", cmd_if.cmd_key, 128'(0));
        checkOutput("mid_rst_block", 128'(cmd_if.cmd_block), 128'(0));
        checkOutput("mid_rst_op", 128'(cmd_if.cmd_op), 128'(0));
        waitCycles(2);
        rst_n   = 1'b1;
        m_op    = 2'd0;
        m_key   = '0;
        m_block = '0;
        waitCycles(1);
        applyStimulus(8'h45, 128'h3b7265747475432d, 8, 1'b1);
        waitCycles(3);
        checkOutput("post_rst_sb_empty", 128'(sb.size()), 128'(0));
        checkOutput("post_rst_errs", 128'((unk_cnt - base_unk) + (to_cnt - base_to) + (ovr_cnt - base_ovr)), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/speck_uart_cmd_parser.md
Name: speck_uart_cmd_parser

Overview:
- Sits between the UART receiver (byte stream plus one-cycle valid strobe) and the Speck command controller.
- Frames raw bytes into complete commands: 'K' (0x4B) followed by a key, 'E' (0x45) followed by a block, 'D' (0x44) followed by a block.
- Presents each assembled command on a valid/ready handshake.
- Rejects unknown opcodes, stalled frames and bytes that arrive while a command is still pending.

Parameters:
- W, 32, Speck word width in bits. Block is 2W bits (W/4 bytes); key is 4W bits (W/2 bytes).
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, UART baud rate. Used only for the timeout.
- TIMEOUT_BYTES, 4, allowed inter-byte gap inside a frame, in 10-bit character times.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, sampled when rx_valid=1
- rx_valid  in  1  single-cycle strobe per received byte
- cmd_ready  in  1  controller can accept a command
- cmd_valid  out  1  assembled command available
- cmd_op  out  2  0=KEY, 1=ENC, 2=DEC (3 is never driven)
- cmd_key  out  4W  key, valid when cmd_op=0
- cmd_block  out  2W  block, valid when cmd_op=1 or 2
- busy  out  1  high while in COLLECT or HOLD
- err_unknown  out  1  1-cycle pulse: bad opcode
- err_timeout  out  1  1-cycle pulse: frame abandoned
- err_overrun  out  1  1-cycle pulse: byte dropped during HOLD

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; byte counter, timeout counter, cmd_key, cmd_block, cmd_op all zero.
  - cmd_valid, busy and all err_* outputs are 0.
- Byte order is little-endian. Payload byte i (0-based after the opcode) is written to bits [8i+7:8i] of the target register.
  - Example: key bytes 00 01 02 03 08 .. 1b give cmd_key=128'h1b1a1918_13121110_0b0a0908_03020100.
- Payload length: KEY = W/2 bytes; ENC/DEC = W/4 bytes.
- Target register handling: the target is cleared when the opcode is accepted. The non-target register keeps its previous value.
- IDLE:
  - rx_valid with 'K', 'E' or 'D': latch cmd_op, clear the count, go to COLLECT.
  - Any other byte: pulse err_unknown next cycle, stay IDLE.
- COLLECT:
  - On each rx_valid: store the byte, increment the count, reset the timeout counter.
  - When the final payload byte is stored, go to HOLD. cmd_valid rises the cycle after that byte's rx_valid (latency 1).
- Timeout:
  - The timeout counter counts every cycle in COLLECT without rx_valid.
  - Limit TO_CYC = TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE, integer-truncated. The counter is sized to hold TO_CYC.
  - On reaching TO_CYC: pulse err_timeout, discard the partial frame (no cmd_valid), go to IDLE.
  - A byte arriving in the same cycle the counter reaches TO_CYC wins: it is stored and no timeout occurs.
- HOLD:
  - cmd_valid=1. cmd_op, cmd_key and cmd_block are stable until the handshake.
  - Transfer happens when cmd_valid & cmd_ready; next cycle cmd_valid=0 and state=IDLE.
  - cmd_ready high on the entry cycle gives a 1-cycle valid pulse.
  - rx_valid during HOLD: the byte is dropped, err_overrun pulses, and the opcode is NOT interpreted.
  - If rx_valid coincides with the handshake cycle, the byte is treated as a new opcode in IDLE, with no overrun.
- cmd_ready is ignored outside HOLD.
- busy = (state != IDLE).
- An opcode byte value (0x4B/0x45/0x44) appearing inside a payload is data, not a new command.
- rst_n assertion mid-frame or mid-HOLD returns everything to reset values immediately. No error pulse is generated.

Optional Feature:
- Macro SPECK_CMD_LOWERCASE_EN.
- Defined: 'k' (0x6B), 'e' (0x65) and 'd' (0x64) are also accepted as opcodes, mapping to KEY/ENC/DEC respectively.
- Undefined: lowercase bytes are unknown opcodes and pulse err_unknown.

Test Plan:
- Key load: send 4B 00 01 02 03 08 09 0a 0b 10 11 12 13 18 19 1a 1b with cmd_ready=1 -> one cmd_valid pulse, cmd_op=0, cmd_key=1b1a1918131211100b0a090803020100.
- Encrypt framing: send 45 2d 43 75 74 74 65 72 3b with cmd_ready=0 -> cmd_valid=1, cmd_op=1, cmd_block=3b7265747475432d. It stays held for 100 cycles; raise cmd_ready -> valid drops next cycle, busy=0.
- Overrun: in HOLD from a 'D' frame, inject byte 0x45 -> err_overrun pulses once. cmd_block is unchanged; after the handshake the parser is IDLE and expects an opcode.
- Unknown and payload opcode: send 0x5A -> err_unknown, stay IDLE. Then 45 4B 4B 4B 4B 4B 4B 4B 4B -> cmd_block=4b4b4b4b4b4b4b4b, cmd_op=1.
- Timeout: with defaults, send 44 11 22 then silence -> err_timeout exactly 34722 cycles after the last byte, no cmd_valid. A gap of 34721 cycles then the remaining 6 bytes -> valid frame.
- Reset mid-frame: send 4B plus 5 key bytes, pulse rst_n low -> busy=0, all outputs 0. A following full 'E' frame decodes correctly.
